mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge_pkg.sv | 23 ++
 rtl/mmio_bridge_if.sv | 12 +
 rtl/mmio_tx_fifo.sv | 53 +++++
 rtl/mmio_bridge.sv | 129 ++++++++++++
 tb/tb_mmio_bridge.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mmio_bridge_pkg.sv
// mmio_bridge_pkg: I/O address map, decode bits and read-source encoding
// shared by the MMIO bridge and its TX FIFO.
package mmio_bridge_pkg;

    localparam logic [31:0] IO_RX_ADDR  = 32'h0003_0000;
    localparam logic [31:0] IO_CNT_ADDR = 32'h0003_0004;
    localparam int          IO_DEC_HI   = 17;
    localparam int          IO_DEC_LO   = 16;
    localparam logic [1:0]  IO_DEC_SEL  = 2'b11;

    typedef enum logic [2:0] {
        SRC_RAM,
        SRC_RX,
        SRC_CNT,
        SRC_SNAP,
        SRC_ZERO
    } rd_src_e;

    function automatic logic is_io_addr(input logic [1:0] dec);
        return dec == IO_DEC_SEL;
    endfunction

endpackage

// File: rtl/mmio_bridge_if.sv
// mmio_bridge_if: CPU-side memory bus of the bridge (address, write data/strobe,
// read data and the TX back-pressure flag).
interface mmio_bridge_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (output mem_a, mem_dout, mem_wr, input mem_din, io_buffer_full);
    modport slave  (input mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);
endinterface

// File: rtl/mmio_tx_fifo.sv
// mmio_tx_fifo: circular byte FIFO with a count register feeding the UART
// transmitter; pushes into a full FIFO are dropped.
module mmio_tx_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop_ready,
    output logic [7:0] head,
    output logic       valid,
    output logic       near_full
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   NEAR_CNT = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, push_ok;

    assign valid     = count != '0;
    assign pop       = valid & pop_ready;
    assign push_ok   = push & (count != FULL_CNT);
    assign head      = mem[rd_ptr];
    // One slot of slack so a write already in flight still fits.
    assign near_full = count >= NEAR_CNT;

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// mmio_bridge: splits CPU accesses between RAM and UART/counter MMIO registers.
// Define MMIO_CYCLE_COUNTER_EN to build the cycle counter and its snapshot.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int TX_FIFO_WIDTH  = 3,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    mmio_bridge_if.slave              cpu,
    output logic                      ram_wr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]                ram_wdata,
    input  logic [7:0]                ram_rdata,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_pop,
    output logic                      halt
);
    logic       io_hit, rd_en, wr_en, rx_hit, cnt_hit;
    logic       push, near_full;
    logic [7:0] push_data;
    rd_src_e    src_d, src_q;
    logic [7:0] rx_q, hold_q, sel_data, din;
    logic       frz_q, halt_q;

    assign io_hit  = is_io_addr(cpu.mem_a[IO_DEC_HI:IO_DEC_LO]);
    assign rd_en   = rdy_in & ~cpu.mem_wr;
    assign wr_en   = rdy_in & cpu.mem_wr;
    assign rx_hit  = io_hit & (cpu.mem_a == IO_RX_ADDR);
    assign cnt_hit = io_hit & (cpu.mem_a == IO_CNT_ADDR);

    assign ram_wr    = wr_en & ~io_hit;
    assign ram_addr  = cpu.mem_a[RAM_ADDR_WIDTH-1:0];
    assign ram_wdata = cpu.mem_dout;
    assign rx_pop    = ~rst_in & rd_en & rx_hit & rx_valid;
    assign halt      = halt_q;

    // The halt write pushes a 0x00 terminator; zero writes to the data port are ignored.
    assign push      = wr_en & (cnt_hit | (rx_hit & (cpu.mem_dout != 8'h00)));
    assign push_data = cnt_hit ? 8'h00 : cpu.mem_dout;

    always_comb begin
        src_d = SRC_ZERO;
        if (!cpu.mem_wr) begin
            if (!io_hit)      src_d = SRC_RAM;
            else if (rx_hit)  src_d = rx_valid ? SRC_RX : SRC_ZERO;
`ifdef MMIO_CYCLE_COUNTER_EN
            else if (cnt_hit) src_d = SRC_CNT;
            else if (cpu.mem_a[31:2] == IO_CNT_ADDR[31:2]) src_d = SRC_SNAP;
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            src_q  <= SRC_ZERO;
            rx_q   <= '0;
            hold_q <= '0;
            frz_q  <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            frz_q  <= ~rdy_in;
            hold_q <= din;
            if (rdy_in) begin
                src_q <= src_d;
                rx_q  <= rx_data;
            end
            if (wr_en & cnt_hit) halt_q <= 1'b1;
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cnt_q, snap_q;
    logic [1:0]  byte_q;
    logic [7:0]  snap_byte;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q  <= '0;
            snap_q <= '0;
            byte_q <= '0;
        end else if (rdy_in) begin
            cnt_q  <= cnt_q + 32'd1;
            byte_q <= cpu.mem_a[1:0];
            if (rd_en & cnt_hit) snap_q <= cnt_q;
        end
    end

    // Byte 0 is read from the freshly latched snapshot, so it equals the live count.
    assign snap_byte = snap_q[{byte_q, 3'b000} +: 8];
`endif

    always_comb begin
        sel_data = 8'h00;
        case (src_q)
            SRC_RAM:  sel_data = ram_rdata;
            SRC_RX:   sel_data = rx_q;
`ifdef MMIO_CYCLE_COUNTER_EN
            SRC_CNT,
            SRC_SNAP: sel_data = snap_byte;
`endif
            default:  sel_data = 8'h00;
        endcase
    end

    // While stalled the RAM keeps following the address, so replay the last value.
    assign din         = frz_q ? hold_q : sel_data;
    assign cpu.mem_din = din;

    mmio_tx_fifo #(.AW(TX_FIFO_WIDTH)) u_tx_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (push),
        .push_data (push_data),
        .pop_ready (tx_ready),
        .head      (tx_data),
        .valid     (tx_valid),
        .near_full (near_full)
    );

    assign cpu.io_buffer_full = near_full;

endmodule

// File: tb/tb_mmio_bridge.sv
// tb_mmio_bridge: directed scenarios then randomized traffic, checked against a
// transaction-level model (TX FIFO as a queue, RAM as an associative array).
module tb_mmio_bridge;

`ifdef MMIO_CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam int          DEPTH = 8;
    localparam logic [31:0] RXA   = 32'h0003_0000;
    localparam logic [31:0] CNTA  = 32'h0003_0004;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, ram_wr, tx_valid, tx_ready, rx_valid, rx_pop, halt;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata, tx_data, rx_data;

    mmio_bridge_if cpu ();

    mmio_bridge #(.TX_FIFO_WIDTH(3), .RAM_ADDR_WIDTH(17)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .cpu       (cpu),
        .ram_wr    (ram_wr),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_pop    (rx_pop),
        .halt      (halt)
    );

    always #5 clk_in = ~clk_in;

    // External synchronous RAM: read data one cycle after the address.
    bit [7:0] ram_mem [0:131071];
    always @(posedge clk_in) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  txq[$];
    bit   [7:0]  ref_ram [int];
    bit          m_halt;
    bit   [31:0] m_cnt, m_snap;
    logic [7:0]  m_din;
    bit          m_din_ok;

    logic [31:0] amap [12] = '{32'h0, 32'h1, 32'h100, 32'h1FFFF, 32'h20010, RXA, RXA,
                               CNTA, 32'h30005, 32'h30006, 32'h30007, 32'h3FFFC};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] a, input bit wr, input logic [7:0] d,
                        input bit rdy = 1'b1, input bit txr = 1'b0, input bit rxv = 1'b0,
                        input logic [7:0] rxd = 8'h00, input bit rst = 1'b0);
        bit io, popped, room;
        rst_in = rst; rdy_in = rdy; tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        cpu.mem_a = a; cpu.mem_wr = wr; cpu.mem_dout = d;
        io = (a[17:16] == 2'b11);
        #1;
        chk("rx_pop", rx_pop, !rst && rdy && !wr && a == RXA && rxv);
        chk("ram_wr", ram_wr, wr && rdy && !io);
        chk("ram_addr", ram_addr, a[16:0]);
        chk("ram_wdata", ram_wdata, d);
        @(posedge clk_in);
        if (rst) begin
            txq.delete();
            m_halt = 0; m_cnt = 0; m_snap = 0; m_din = 8'h00; m_din_ok = 1;
        end else begin
            popped = txq.size() > 0 && txr;
            room   = txq.size() < DEPTH;
            if (popped) void'(txq.pop_front());
            if (rdy) begin
                if (wr) begin
                    m_din_ok = 0;
                    if (!io) ref_ram[int'(a[16:0])] = d;
                    else if (a == RXA && d != 8'h00 && room) txq.push_back(d);
                    else if (a == CNTA) begin
                        m_halt = 1;
                        if (room) txq.push_back(8'h00);
                    end
                end else begin
                    m_din_ok = 1;
                    if (!io) m_din = ref_ram.exists(int'(a[16:0])) ? ref_ram[int'(a[16:0])] : 8'h00;
                    else if (a == RXA) m_din = rxv ? rxd : 8'h00;
                    else if (CNTA == a && CNT_EN) begin
                        m_snap = m_cnt;
                        m_din  = m_cnt[7:0];
                    end else if (a > CNTA && a <= 32'h30007 && CNT_EN) m_din = 8'(m_snap >> (8 * a[1:0]));
                    else m_din = 8'h00;
                end
                m_cnt++;
            end
        end
        @(negedge clk_in);
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("io_buffer_full", cpu.io_buffer_full, txq.size() >= DEPTH - 1);
        chk("halt", halt, m_halt);
        if (m_din_ok) chk("mem_din", cpu.mem_din, m_din);
    endtask

    initial begin
        logic [31:0] a;
        bit          wr, rdy, txr, rxv, rst;
        logic [7:0]  d, rxd;

        // reset state
        step(32'h0, 0, 8'h00, 1, 0, 0, 8'h00, 1);
        step(32'h0, 0, 8'h00, 1, 0, 0, 8'h00, 1);
        chk("rst_mem_din", cpu.mem_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_full", cpu.io_buffer_full, 1'b0);
        chk("rst_halt", halt, 1'b0);

        // single push, zero write ignored
        step(RXA, 1, 8'h41);
        chk("push41_valid", tx_valid, 1'b1);
        chk("push41_data", tx_data, 8'h41);
        step(RXA, 1, 8'h00);
        chk("zero_ignored_data", tx_data, 8'h41);
        step(32'h0, 0, 8'h00, 1, 1);
        chk("zero_ignored_empty", tx_valid, 1'b0);

        // fill to near-full, full, drop, ordered drain
        for (int i = 1; i <= 7; i++) begin
            step(RXA, 1, 8'(i));
            chk("near_full", cpu.io_buffer_full, i == 7);
        end
        step(RXA, 1, 8'h08);
        step(RXA, 1, 8'h09);
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", tx_data, 8'(i));
            step(32'h0, 0, 8'h00, 1, 1);
        end
        chk("drain_empty", tx_valid, 1'b0);

        // RX read with and without data
        step(RXA, 0, 8'h00, 1, 0, 1, 8'h7E);
        chk("rx_data", cpu.mem_din, 8'h7E);
        step(32'h0, 0, 8'h00, 1, 0, 1, 8'h7E);
        step(RXA, 0, 8'h00, 1, 0, 0, 8'h55);
        chk("rx_empty", cpu.mem_din, 8'h00);

        // RAM read latency and stall hold
        step(32'h100, 1, 8'h5A);
        step(32'h100, 0, 8'h00);
        chk("ram_read", cpu.mem_din, 8'h5A);
        step(CNTA, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step(32'h0, 0, 8'h00, 0);
            chk("stall_hold", cpu.mem_din, CNT_EN ? m_cnt[7:0] - 8'd1 : 8'h00);
        end
        step(CNTA, 0, 8'h00);

        // reset discards a pending read
        step(32'h100, 0, 8'h00);
        step(32'h0, 0, 8'h00, 1, 0, 0, 8'h00, 1);
        chk("rst_midread", cpu.mem_din, 8'h00);

        // halt write
        step(CNTA, 1, 8'hAA);
        chk("halt_set", halt, 1'b1);
        chk("halt_push_valid", tx_valid, 1'b1);
        chk("halt_push_data", tx_data, 8'h00);
        step(32'h0, 0, 8'h00, 1, 0, 0, 8'h00, 1);
        chk("halt_clr", halt, 1'b0);
        chk("halt_fifo_empty", tx_valid, 1'b0);

        // counter snapshot at 0x1234
        while (m_cnt < 32'h1234) step(32'h0, 0, 8'h00);
        step(CNTA, 0, 8'h00);
        chk("snap_b0", cpu.mem_din, CNT_EN ? 8'h34 : 8'h00);
        step(32'h30005, 0, 8'h00);
        chk("snap_b1", cpu.mem_din, CNT_EN ? 8'h12 : 8'h00);
        step(32'h30006, 0, 8'h00);
        chk("snap_b2", cpu.mem_din, 8'h00);
        step(32'h30007, 0, 8'h00);
        chk("snap_b3", cpu.mem_din, 8'h00);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            a   = amap[$urandom_range(0, 11)];
            wr  = $urandom_range(0, 3) == 0;
            d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            rdy = $urandom_range(0, 4) != 0;
            txr = $urandom_range(0, 1) == 1;
            rxv = $urandom_range(0, 1) == 1;
            rxd = 8'($urandom);
            rst = $urandom_range(0, 99) == 0;
            if (rst) wr = 0;
            step(a, wr, d, rdy, txr, rxv, rxd, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
